// File: rtl/mux_scan_pkg.sv
// Shared constants for the mux scan controller: FSM state encodings and
// channel indices of the 4:1 mux being scanned.
package mux_scan_pkg;

  localparam int NUM_CH = 4;

  typedef logic [1:0] ch_t;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETTLE = 2'd1;
  localparam logic [1:0] SAMPLE = 2'd2;
  localparam logic [1:0] HOLD   = 2'd3;

  localparam ch_t CH_A = 2'd0;
  localparam ch_t CH_B = 2'd1;
  localparam ch_t CH_C = 2'd2;
  localparam ch_t CH_D = 2'd3;

endpackage

// File: rtl/mux_scan_controller_if.sv
// Signal bundle between the scan controller, the scanned mux and the
// downstream consumer of the assembled 4-bit word.
interface mux_scan_controller_if;
  import mux_scan_pkg::*;

  logic              start;
  logic              s1;
  logic              s0;
  logic              y;
  logic              busy;
  logic [NUM_CH-1:0] data_out;
  logic              data_valid;
  logic              data_ready;

  modport master (
    input  start, y, data_ready,
    output s1, s0, busy, data_out, data_valid
  );

  modport slave (
    output start, y, data_ready,
    input  s1, s0, busy, data_out, data_valid
  );

endinterface

// File: rtl/mux_scan_controller.sv
// Steps the mux select through channels a..d, lets each settle, samples y,
// and hands the assembled word downstream with a valid/ready handshake.
module mux_scan_controller
  import mux_scan_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic           clk,
  input  logic           rst,
  mux_scan_controller_if.master bus
);

  localparam int CNT_RAW = $clog2(SETTLE_CYCLES + 1);
  localparam int CNT_W   = (CNT_RAW < 1) ? 1 : CNT_RAW;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

  if (SETTLE_CYCLES < 1) begin : g_bad_settle
    $error("mux_scan_controller: SETTLE_CYCLES must be >= 1");
  end

  logic [1:0]        state;
  ch_t               sel;
  logic [CNT_W-1:0]  cnt;
  logic [NUM_CH-2:0] cap_buf;
  logic [NUM_CH-1:0] data_out_r;
  logic              data_valid_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      sel          <= CH_A;
      cnt          <= '0;
      cap_buf      <= '0;
      data_out_r   <= '0;
      data_valid_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            sel   <= CH_A;
            cnt   <= '0;
            state <= SETTLE;
          end
        end
        SETTLE: begin
          cnt <= cnt + 1'b1;
          if (cnt == CNT_LAST) state <= SAMPLE;
        end
        SAMPLE: begin
          if (sel != CH_D) begin
            for (int i = 0; i < NUM_CH - 1; i++) begin
              if (sel == ch_t'(i)) cap_buf[i] <= bus.y;
            end
            sel   <= sel + 2'd1;
            cnt   <= '0;
            state <= SETTLE;
          end else begin
            // Channel d goes straight into the output word alongside a..c.
            data_out_r   <= {bus.y, cap_buf};
            data_valid_r <= 1'b1;
            state        <= HOLD;
          end
        end
        HOLD: begin
          if (bus.data_ready) begin
            data_valid_r <= 1'b0;
            sel          <= CH_A;
            state        <= IDLE;
          end
        end
      endcase
    end
  end

  assign bus.s1         = sel[1];
  assign bus.s0         = sel[0];
  assign bus.busy       = (state != IDLE);
  assign bus.data_out   = data_out_r;
  assign bus.data_valid = data_valid_r;

endmodule

// File: tb/tb_mux_scan_controller.sv
// Directed bench: two controllers (settle 1 and 3) each scanning a NAND-built
// 4:1 mux whose output is looped back as y.
module tb_mux_scan_controller;

  logic clk = 1'b0;
  logic rst;
  logic a, b, c, d;
  int   n_chk  = 0;
  int   n_pass = 0;

  mux_scan_controller_if bus1 ();
  mux_scan_controller_if bus3 ();

  mux_scan_controller #(.SETTLE_CYCLES(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  mux_scan_controller #(.SETTLE_CYCLES(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

  assign bus1.y = ~(~(a & ~bus1.s1 & ~bus1.s0) & ~(b & ~bus1.s1 & bus1.s0) &
                    ~(c &  bus1.s1 & ~bus1.s0) & ~(d &  bus1.s1 & bus1.s0));
  assign bus3.y = ~(~(a & ~bus3.s1 & ~bus3.s0) & ~(b & ~bus3.s1 & bus3.s0) &
                    ~(c &  bus3.s1 & ~bus3.s0) & ~(d &  bus3.s1 & bus3.s0));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (got timeout, required completion)");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start1();
    bus1.start = 1'b1;
    step();
    bus1.start = 1'b0;
  endtask

  task automatic wait_valid1(input int limit, output int n);
    n = 0;
    while (!bus1.data_valid && n < limit) begin
      step();
      n++;
    end
  endtask

  task automatic set_abcd(input logic [3:0] v);
    {a, b, c, d} = v;
  endtask

  initial begin
    int n;
    int seen;
    rst = 1'b1;
    bus1.start = 1'b0; bus1.data_ready = 1'b0;
    bus3.start = 1'b0; bus3.data_ready = 1'b0;
    set_abcd(4'b0000);
    step();
    step();
    rst = 1'b0;

    chk("rst_sel", {bus1.s1, bus1.s0}, 2'b00);
    chk("rst_busy", bus1.busy, 1'b0);
    chk("rst_valid", bus1.data_valid, 1'b0);
    chk("rst_data", bus1.data_out, 4'b0000);
    chk("rst3_busy", bus3.busy, 1'b0);
    chk("rst3_data", bus3.data_out, 4'b0000);

    // Test 1: a,b,c,d = 1,0,0,1
    set_abcd(4'b1001);
    bus1.data_ready = 1'b1;
    pulse_start1();
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("t1_sel_%0d", k), {bus1.s1, bus1.s0}, k / 2);
      chk($sformatf("t1_vld_%0d", k), bus1.data_valid, 1'b0);
      step();
    end
    chk("t1_valid", bus1.data_valid, 1'b1);
    chk("t1_data", bus1.data_out, 4'b1001);
    chk("t1_busy", bus1.busy, 1'b1);
    step();
    chk("t1_valid_drop", bus1.data_valid, 1'b0);
    chk("t1_idle", bus1.busy, 1'b0);
    chk("t1_sel_back", {bus1.s1, bus1.s0}, 2'b00);
    chk("t1_data_kept", bus1.data_out, 4'b1001);

    // Test 2: a,b,c,d = 0,1,1,0
    set_abcd(4'b0110);
    pulse_start1();
    wait_valid1(20, n);
    chk("t2_latency", n, 8);
    chk("t2_data", bus1.data_out, 4'b0110);
    chk("t2_busy_hold", bus1.busy, 1'b1);
    step();
    chk("t2_busy_drop", bus1.busy, 1'b0);
    chk("t2_valid_drop", bus1.data_valid, 1'b0);

    // Test 3: backpressure
    set_abcd(4'b1001);
    bus1.data_ready = 1'b0;
    pulse_start1();
    wait_valid1(20, n);
    chk("t3_latency", n, 8);
    set_abcd(4'b0000);
    for (int k = 0; k < 5; k++) begin
      step();
      chk($sformatf("t3_valid_%0d", k), bus1.data_valid, 1'b1);
      chk($sformatf("t3_data_%0d", k), bus1.data_out, 4'b1001);
      chk($sformatf("t3_sel_%0d", k), {bus1.s1, bus1.s0}, 2'b11);
      chk($sformatf("t3_busy_%0d", k), bus1.busy, 1'b1);
    end
    bus1.data_ready = 1'b1;
    step();
    chk("t3_release", bus1.data_valid, 1'b0);
    chk("t3_data_kept", bus1.data_out, 4'b1001);

    // Test 4: start re-pulsed mid-scan and in HOLD
    set_abcd(4'b0110);
    bus1.data_ready = 1'b0;
    pulse_start1();
    step();
    step();
    bus1.start = 1'b1;
    step();
    bus1.start = 1'b0;
    step(); step(); step(); step();
    chk("t4_no_early_valid", bus1.data_valid, 1'b0);
    step();
    chk("t4_valid", bus1.data_valid, 1'b1);
    chk("t4_data", bus1.data_out, 4'b0110);
    bus1.start = 1'b1;
    step();
    chk("t4_hold_ignores_start", bus1.data_valid, 1'b1);
    bus1.data_ready = 1'b1;
    step();
    bus1.start = 1'b0;
    chk("t4_idle", bus1.busy, 1'b0);
    chk("t4_valid_drop", bus1.data_valid, 1'b0);
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (bus1.busy || bus1.data_valid) seen++;
    end
    chk("t4_start_dropped", seen, 0);

    // Test 5: reset mid-scan
    set_abcd(4'b1001);
    pulse_start1();
    step(); step(); step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t5_sel", {bus1.s1, bus1.s0}, 2'b00);
    chk("t5_busy", bus1.busy, 1'b0);
    chk("t5_valid", bus1.data_valid, 1'b0);
    chk("t5_data", bus1.data_out, 4'b0000);
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (bus1.data_valid) seen++;
    end
    chk("t5_no_result", seen, 0);
    set_abcd(4'b0110);
    pulse_start1();
    wait_valid1(20, n);
    chk("t5_latency", n, 8);
    chk("t5_data_after", bus1.data_out, 4'b0110);
    step();

    // Test 6: SETTLE_CYCLES = 3, a,b,c,d = 1,1,0,1
    set_abcd(4'b1101);
    bus3.data_ready = 1'b1;
    bus3.start = 1'b1;
    step();
    bus3.start = 1'b0;
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("t6_sel_%0d", k), {bus3.s1, bus3.s0}, k / 4);
      chk($sformatf("t6_vld_%0d", k), bus3.data_valid, 1'b0);
      step();
    end
    chk("t6_valid", bus3.data_valid, 1'b1);
    chk("t6_data", bus3.data_out, 4'b1011);
    step();
    chk("t6_valid_drop", bus3.data_valid, 1'b0);
    chk("t6_idle", bus3.busy, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
